// File: rtl/cbud_timer_ctrl.sv
// Sequencer for a cascaded 4-bit up/down counter chain: load, run, tick, reload/clear.
// Optional terminal-value checker enabled by defining CBUD_TCTRL_TERMCHK_EN.
`timescale 1ns/1ps
module cbud_timer_ctrl #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         START,
  input  logic         STOP,
  input  logic         PAUSE,
  input  logic         MODE,
  input  logic         DIR,
  input  logic [W-1:0] PERIOD,
  input  logic [W-1:0] CNT_Q,
  input  logic         CNT_CAO,
  output logic [W-1:0] CNT_D,
  output logic         CNT_LD,
  output logic         CNT_CS,
  output logic         CNT_EN,
  output logic         CNT_CAI,
  output logic         CNT_DNUP,
  output logic         BUSY,
  output logic         TICK,
  output logic         DONE,
  output logic         ERR
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t       state_r;
  logic [W-1:0] prd_r;
  logic         dir_r;
  logic         mode_r;
  logic         busy_r;
  logic         tick_r;
  logic         done_r;

  logic [W-1:0] load_val_s;
  logic         run_en_s;
  logic         term_s;
  logic [W-1:0] cnt_d_s;
  logic         cnt_ld_s;
  logic         cnt_cs_s;

  // Up-counting starts from the complement so both directions reach terminal after prd_r steps.
  assign load_val_s = dir_r ? prd_r : ~prd_r;
  assign run_en_s   = (state_r == S_RUN) && !PAUSE && !STOP;
  assign term_s     = run_en_s && CNT_CAO;

  // Chain control pins; these must react in the same cycle to STOP and the terminal carry.
  always_comb begin
    cnt_d_s  = {W{1'b0}};
    cnt_ld_s = 1'b0;
    cnt_cs_s = 1'b0;
    case (state_r)
      S_LOAD: begin
        if (STOP) begin
          cnt_cs_s = 1'b1;
        end else begin
          cnt_ld_s = 1'b1;
          cnt_d_s  = load_val_s;
        end
      end
      S_RUN: begin
        if (STOP) begin
          cnt_cs_s = 1'b1;
        end else if (term_s) begin
          if (mode_r) begin
            cnt_ld_s = 1'b1;
            cnt_d_s  = load_val_s;
          end else begin
            cnt_cs_s = 1'b1;
          end
        end else begin
          cnt_ld_s = 1'b0;
        end
      end
      default: begin
        cnt_ld_s = 1'b0;
      end
    endcase
  end

  assign CNT_D    = cnt_d_s;
  assign CNT_LD   = cnt_ld_s;
  assign CNT_CS   = cnt_cs_s;
  assign CNT_EN   = run_en_s;
  assign CNT_CAI  = run_en_s;
  assign CNT_DNUP = dir_r;
  assign BUSY     = busy_r;
  assign TICK     = tick_r;
  assign DONE     = done_r;

  // Sequencing FSM with registered status pulses.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_r <= S_IDLE;
      prd_r   <= {W{1'b0}};
      dir_r   <= 1'b0;
      mode_r  <= 1'b0;
      busy_r  <= 1'b0;
      tick_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (START && !STOP) begin
            prd_r   <= PERIOD;
            dir_r   <= DIR;
            mode_r  <= MODE;
            state_r <= S_LOAD;
            busy_r  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (STOP) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= S_RUN;
          end
        end
        S_RUN: begin
          if (STOP) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end else if (term_s) begin
            tick_r <= 1'b1;
            if (!mode_r) begin
              done_r  <= 1'b1;
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CBUD_TCTRL_TERMCHK_EN
  logic         err_r;
  logic [W-1:0] term_val_s;

  assign term_val_s = dir_r ? {W{1'b0}} : {W{1'b1}};
  assign ERR        = err_r;

  // Sticky flag: a carry out while the chain is not at its terminal value.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      err_r <= 1'b0;
    end else if ((state_r == S_RUN) && CNT_CAO && (CNT_Q != term_val_s)) begin
      err_r <= 1'b1;
    end
  end
`else
  logic unused_cnt_q_s;
  assign unused_cnt_q_s = ^CNT_Q;
  assign ERR            = 1'b0;
`endif

endmodule

// File: tb/tb_cbud_timer_ctrl.sv
// Self-checking bench: behavioural counter chain plus a cycle-count reference model.
`timescale 1ns/1ps
module tb_cbud_timer_ctrl;
  localparam int W = 8;
`ifdef CBUD_TCTRL_TERMCHK_EN
  localparam bit TERMCHK = 1'b1;
`else
  localparam bit TERMCHK = 1'b0;
`endif

  logic         CLK;
  logic         RSTN, START, STOP, PAUSE, MODE, DIR;
  logic [W-1:0] PERIOD;
  logic [W-1:0] CNT_Q;
  logic         CNT_CAO;
  logic [W-1:0] CNT_D;
  logic         CNT_LD, CNT_CS, CNT_EN, CNT_CAI, CNT_DNUP, BUSY, TICK, DONE, ERR;
  logic         force_cao;

  int n_checks = 0;
  int n_errors = 0;

  cbud_timer_ctrl #(.W(W)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .STOP(STOP), .PAUSE(PAUSE),
    .MODE(MODE), .DIR(DIR), .PERIOD(PERIOD), .CNT_Q(CNT_Q), .CNT_CAO(CNT_CAO),
    .CNT_D(CNT_D), .CNT_LD(CNT_LD), .CNT_CS(CNT_CS), .CNT_EN(CNT_EN),
    .CNT_CAI(CNT_CAI), .CNT_DNUP(CNT_DNUP), .BUSY(BUSY), .TICK(TICK),
    .DONE(DONE), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Counter chain: clear beats load beats count; carry out only while carry in is high.
  logic [W-1:0] chain_q = '0;
  always @(posedge CLK) begin
    if (CNT_CS)                chain_q <= '0;
    else if (CNT_LD)           chain_q <= CNT_D;
    else if (CNT_EN && CNT_CAI) chain_q <= CNT_DNUP ? chain_q - 1'b1 : chain_q + 1'b1;
  end
  assign CNT_Q   = chain_q;
  assign CNT_CAO = (CNT_CAI && (CNT_DNUP ? (chain_q == '0) : (chain_q == '1))) || force_cao;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: phase, captured settings and remaining enabled cycles to the next terminal count.
  int           m_phase, m_left, lv, e_d;
  logic [W-1:0] m_prd;
  logic         m_dir, m_mode, m_tick, m_done, m_err, m_valid;
  logic         e_en, e_ld, e_cs, term;

  initial begin
    m_valid = 0; m_phase = 0; m_left = 0; m_prd = '0;
    m_dir = 0; m_mode = 0; m_tick = 0; m_done = 0; m_err = 0;
    forever begin
      @(negedge CLK);
      lv = m_dir ? int'(m_prd) : (2**W - 1) - int'(m_prd);
      e_en = 0; e_ld = 0; e_cs = 0; term = 0;
      if (m_phase == 1) begin
        if (STOP) e_cs = 1; else e_ld = 1;
      end else if (m_phase == 2) begin
        e_en = !PAUSE && !STOP;
        if (STOP) e_cs = 1;
        else if (e_en && (m_left == 1 || force_cao)) begin
          term = 1;
          if (m_mode) e_ld = 1; else e_cs = 1;
        end
      end
      e_d = e_ld ? lv : 0;
      if (m_valid) begin
        chk("busy",  32'(BUSY),     32'(m_phase != 0));
        chk("ld",    32'(CNT_LD),   32'(e_ld));
        chk("cs",    32'(CNT_CS),   32'(e_cs));
        chk("en",    32'(CNT_EN),   32'(e_en));
        chk("cai",   32'(CNT_CAI),  32'(e_en));
        chk("dnup",  32'(CNT_DNUP), 32'(m_dir));
        chk("cnt_d", 32'(CNT_D),    e_d);
        chk("tick",  32'(TICK),     32'(m_tick));
        chk("done",  32'(DONE),     32'(m_done));
        chk("err",   32'(ERR),      32'(m_err));
      end
      if (!RSTN) begin
        m_valid = 1; m_phase = 0; m_prd = '0; m_dir = 0; m_mode = 0;
        m_tick = 0; m_done = 0; m_err = 0;
      end else begin
        if (TERMCHK && term && force_cao && m_left != 1) m_err = 1;
        m_tick = term;
        m_done = term && !m_mode;
        case (m_phase)
          0: if (START && !STOP) begin
               m_prd = PERIOD; m_dir = DIR; m_mode = MODE; m_phase = 1;
             end
          1: if (STOP) m_phase = 0;
             else begin m_phase = 2; m_left = int'(m_prd) + 1; end
          default: begin
            if (STOP) m_phase = 0;
            else if (term) begin
              if (m_mode) m_left = int'(m_prd) + 1; else m_phase = 0;
            end else if (e_en) m_left--;
          end
        endcase
      end
    end
  end

  int ticks[$];
  int first_tick;
  int exp_ticks[5] = '{12, 25, 35, 45, 55};

  initial begin
    RSTN = 0; START = 1; STOP = 0; PAUSE = 0; MODE = 0; DIR = 1;
    PERIOD = 8'd3; force_cao = 0;
    // Reset held with START high: everything quiet.
    step(); step();
    @(negedge CLK);
    chk("rst_outs", 32'({BUSY, TICK, DONE, ERR, CNT_LD, CNT_CS, CNT_EN, CNT_CAI, CNT_DNUP}), 32'd0);
    chk("rst_d", 32'(CNT_D), 32'd0);
    step();
    RSTN = 1;
    // One-shot down, PERIOD=3: START accepted at the first edge after reset release.
    step();
    START = 0;
    @(negedge CLK);
    chk("os_ld", 32'(CNT_LD), 32'd1);
    chk("os_d", 32'(CNT_D), 32'd3);
    first_tick = -1;
    for (int c = 2; c <= 12; c++) begin
      @(negedge CLK);
      if (TICK && first_tick < 0) first_tick = c;
      if (c == 6) chk("os_done", 32'(DONE), 32'd1);
      if (c == 7) begin
        chk("os_busy_after", 32'(BUSY), 32'd0);
        chk("os_chain_after", 32'(chain_q), 32'd0);
      end
    end
    chk("os_tick_cycle", 32'(first_tick), 32'd6);
    step();

    // Periodic up, PERIOD=9, with a 3-cycle pause in the second period.
    MODE = 1; DIR = 0; PERIOD = 8'd9; START = 1;
    step();
    START = 0;
    for (int c = 1; c <= 60; c++) begin
      PAUSE = (c >= 15 && c <= 17);
      @(negedge CLK);
      if (c == 1) chk("per_d", 32'(CNT_D), 32'd246);
      if (TICK) ticks.push_back(c);
      step();
    end
    PAUSE = 0;
    chk("per_nticks", 32'(ticks.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < ticks.size()) chk("per_tick_cycle", 32'(ticks[i]), 32'(exp_ticks[i]));
    STOP = 1;
    step();
    STOP = 0;

    // STOP coinciding with the terminal carry (periodic down, PERIOD=2).
    MODE = 1; DIR = 1; PERIOD = 8'd2; START = 1;
    step();
    START = 0;
    step(); step(); step();
    STOP = 1;
    @(negedge CLK);
    chk("stop_cs", 32'(CNT_CS), 32'd1);
    chk("stop_en", 32'(CNT_EN), 32'd0);
    step();
    STOP = 0;
    @(negedge CLK);
    chk("stop_tick", 32'(TICK), 32'd0);
    chk("stop_busy", 32'(BUSY), 32'd0);
    step();
    START = 1; STOP = 1;
    step();
    START = 0; STOP = 0;
    @(negedge CLK);
    chk("startstop_idle", 32'(BUSY), 32'd0);
    step();

    // PERIOD=0 periodic down: tick every cycle; a START while busy is ignored.
    MODE = 1; DIR = 1; PERIOD = 8'd0; START = 1;
    step();
    START = 0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 4) begin START = 1; PERIOD = 8'd5; DIR = 0; MODE = 0; end
      else START = 0;
      @(negedge CLK);
      if (c >= 3) chk("p0_tick", 32'(TICK), 32'd1);
      if (c >= 4) chk("p0_dnup", 32'(CNT_DNUP), 32'd1);
      step();
    end
    STOP = 1;
    step();
    STOP = 0;
    step();

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      RSTN   = ($urandom_range(0, 299) != 0);
      START  = ($urandom_range(0, 3) == 0);
      STOP   = ($urandom_range(0, 19) == 0);
      PAUSE  = ($urandom_range(0, 4) == 0);
      MODE   = 1'($urandom_range(0, 1));
      DIR    = 1'($urandom_range(0, 1));
      PERIOD = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      force_cao = ($urandom_range(0, 49) == 0) && !PAUSE && !STOP;
      step();
    end

    // Forced carry mid-count: ERR only with the checker built in, sticky until reset.
    RSTN = 0; START = 0; STOP = 0; PAUSE = 0; force_cao = 0;
    step();
    RSTN = 1; MODE = 1; DIR = 1; PERIOD = 8'd10; START = 1;
    step();
    START = 0;
    step(); step(); step();
    force_cao = 1;
    step();
    force_cao = 0;
    @(negedge CLK);
    chk("err_set", 32'(ERR), 32'(TERMCHK));
    chk("forced_tick", 32'(TICK), 32'd1);
    step(); step(); step();
    @(negedge CLK);
    chk("err_sticky", 32'(ERR), 32'(TERMCHK));
    step();
    RSTN = 0;
    step();
    RSTN = 1;
    @(negedge CLK);
    chk("err_cleared", 32'(ERR), 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cbud_timer_ctrl.md
# cbud_timer_ctrl

Sequencing controller for a cascaded up/down counter chain built from 4-bit up/down counter stages with load, synchronous clear, enable and carry in/out. It accepts start/stop/pause commands from one requester, loads the chain with a period-derived preset, runs it in the requested direction, and converts the chain's terminal carry into a single-cycle tick. It supports one-shot and periodic (auto-reload) operation. It sits between control logic and the counter datapath and owns every control pin of the chain.

## Interface
- W, 4, chain width in bits; legal values 4, 8, 12, 16.
- CLK  in  1  clock; all state changes on rising edge.
- RSTN  in  1  synchronous active-low reset.
- START  in  1  start request; sampled only in IDLE.
- STOP  in  1  abort request; sampled in LOAD and RUN.
- PAUSE  in  1  level; freezes the count while high in RUN.
- MODE  in  1  0 = one-shot, 1 = periodic; captured on START.
- DIR  in  1  0 = count up, 1 = count down; captured on START.
- PERIOD  in  W  tick interval minus 1; captured on START.
- CNT_Q  in  W  chain count value.
- CNT_CAO  in  1  carry out of the last chain stage.
- CNT_D  out  W  parallel load data.
- CNT_LD  out  1  synchronous load.
- CNT_CS  out  1  synchronous clear.
- CNT_EN  out  1  count enable, all stages.
- CNT_CAI  out  1  carry in of the first stage; always equal to CNT_EN.
- CNT_DNUP  out  1  direction; equal to the captured DIR.
- BUSY  out  1  high in LOAD and RUN.
- TICK  out  1  registered one-cycle pulse per terminal count.
- DONE  out  1  registered one-cycle pulse on one-shot completion.
- ERR  out  1  sticky terminal-check error (see Configuration).

## Operation
- Reset (RSTN=0 at an edge): state IDLE; prd_r, dir_r, mode_r, TICK, DONE and ERR all 0. All outputs 0 in the cycle after reset. Reset overrides every other input and applies mid-operation as well; the chain is not cleared by reset.
- State IDLE: CNT_EN=0, CNT_LD=0, CNT_CS=0. START=1 and STOP=0 captures PERIOD, DIR and MODE, then moves to LOAD. If START and STOP are both 1, the block stays in IDLE.
- State LOAD (one cycle): CNT_LD=1. CNT_D is prd_r when down-counting and ~prd_r (equal to 2^W-1-prd_r) when up-counting. Next state is RUN. STOP=1 instead drives CNT_LD=0 and CNT_CS=1, and the next state is IDLE.
- State RUN: CNT_EN = ~PAUSE.
  - CNT_CAO=1 (only possible while enabled) is the terminal event. TICK is set for the next cycle.
  - Periodic mode: CNT_LD=1 with CNT_D as in LOAD, combinationally in the same cycle, so the chain reloads instead of wrapping. State stays RUN.
  - One-shot mode: CNT_CS=1 in the same cycle, next state is IDLE, and DONE is set for the next cycle.
  - STOP=1: CNT_CS=1, CNT_EN=0, next state IDLE, no TICK and no DONE. STOP beats a simultaneous CNT_CAO.
- START while BUSY is ignored. PERIOD, DIR and MODE changes while BUSY have no effect.
- Arithmetic: the load value is computed in W bits. PERIOD=0 yields a terminal count on the first enabled RUN cycle, so the tick interval is 1.

## Timing
- START sampled at edge k: LOAD during cycle k+1, RUN from k+2. The chain holds the load value in the first RUN cycle.
- Unpaused down count of P: CNT_CAO is high in RUN cycle P+1, and TICK follows one cycle later.
- Periodic TICK spacing is exactly PERIOD+1 cycles, plus one cycle for each paused cycle.
- STOP latency: IDLE in the cycle after the sampling edge, and the chain is 0 after that same edge.
- TICK and DONE are never high for more than one consecutive cycle. In one-shot mode DONE and the final TICK are coincident.

## Configuration
- Macro CBUD_TCTRL_TERMCHK_EN.
- Defined: in RUN, CNT_CAO=1 while CNT_Q is not the terminal value (0 when down, all ones when up) sets ERR. ERR stays set until reset and has no effect on sequencing.
- Undefined: CNT_Q is unused and ERR is tied to 0.

## Test plan
- Reset: hold RSTN=0 for 2 cycles while START=1 -> all outputs 0 and BUSY=0. Release reset -> START accepted on the first active edge.
- One-shot down with W=4, PERIOD=3, DIR=1, MODE=0, START pulse at edge 0 -> CNT_LD=1 with CNT_D=3 in cycle 1; CNT_CAO in cycle 5; TICK=DONE=1 in cycle 6; BUSY=0 and chain=0 afterward.
- Periodic up with W=8, PERIOD=9, DIR=0 -> CNT_D=246; TICK every 10 cycles across 5 periods. PAUSE high for 3 cycles in the second period -> that interval becomes 13.
- STOP in the same cycle as CNT_CAO (periodic, PERIOD=2) -> no TICK, CNT_CS=1, IDLE next cycle. START and STOP together in IDLE -> stays IDLE.
- PERIOD=0 periodic down -> TICK every cycle from cycle 3 onward. START while BUSY is ignored, and the captured values are unchanged.
- With CBUD_TCTRL_TERMCHK_EN defined: force CNT_CAO=1 with CNT_Q=5 in RUN -> ERR=1 next cycle and sticky until RSTN=0. With the macro undefined: ERR stays 0.
